// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues hold/reset/set/toggle commands and replays each
// one as a registered J/K pair for cmd_rep+1 cycles, with an optional gap.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   cmd_valid  command present on cmd_op/cmd_rep
//   cmd_ready  FIFO can accept (equals !full, no bypass on pop)
//   cmd_op     {J,K}: 00 hold, 01 reset, 10 set, 11 toggle
//   cmd_rep    repeat count minus one
//   J, K       registered drive to the downstream JK flip-flop
//   busy       FSM not idle or FIFO non-empty
//   done       J/K carry the last repetition of a command this cycle
//   fifo_cnt   current FIFO occupancy
//   q_model    registered model of the downstream flip-flop
//              (only with JK_SEQ_SHADOW_Q_EN defined)
//
// Parameters: DEPTH (power of two, >= 2), CNT_W (repeat field width),
// GAP_CYC (idle cycles after each command, 0..15).
// Optional macro: JK_SEQ_SHADOW_Q_EN adds the q_model output.

module jk_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [CNT_W-1:0]         cmd_rep,
    output logic                     J,
    output logic                     K,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_cnt
`ifdef JK_SEQ_SHADOW_Q_EN
    ,
    output logic                     q_model
`endif
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] REP_ONE = CNT_W'(1);

    // The IDLE cycle that follows GAP counts as the last gap cycle, so
    // GAP lasts GAP_CYC-1 cycles and GAP_CYC==1 goes straight to IDLE.
    localparam logic [3:0] GAP_LD = 4'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP
    } state_t;

    state_t state;

    // FIFO storage and pointers
    logic [1:0]       op_mem  [DEPTH];
    logic [CNT_W-1:0] rep_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_rep;

    logic [CNT_W-1:0] rep_cnt;
    logic [3:0]       gap_cnt;

    assign full      = (fifo_cnt == FULL_CNT);
    assign empty     = (fifo_cnt == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;

    assign head_op   = op_mem[rd_ptr];
    assign head_rep  = rep_mem[rd_ptr];

    assign busy      = (state != S_IDLE) || !empty;

    // Pop from IDLE, or seamlessly at the end of a command when no gap.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            unique case (1'b1)
                (state == S_IDLE):
                    pop = 1'b1;
                (state == S_ISSUE):
                    pop = (rep_cnt == '0) && (GAP_CYC == 0);
                default:
                    pop = 1'b0;
            endcase
        end
    end

    // Storage is not reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]  <= cmd_op;
            rep_mem[wr_ptr] <= cmd_rep;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Sequencer FSM; J, K and done are all registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            J       <= 1'b0;
            K       <= 1'b0;
            done    <= 1'b0;
            rep_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        J       <= head_op[1];
                        K       <= head_op[0];
                        rep_cnt <= head_rep;
                        done    <= (head_rep == '0);
                        state   <= S_ISSUE;
                    end else begin
                        J <= 1'b0;
                        K <= 1'b0;
                    end
                end

                S_ISSUE: begin
                    if (rep_cnt != '0) begin
                        rep_cnt <= rep_cnt - REP_ONE;
                        done    <= (rep_cnt == REP_ONE);
                    end else if (pop) begin
                        J       <= head_op[1];
                        K       <= head_op[0];
                        rep_cnt <= head_rep;
                        done    <= (head_rep == '0);
                    end else if (GAP_CYC > 1) begin
                        J       <= 1'b0;
                        K       <= 1'b0;
                        gap_cnt <= GAP_LD;
                        state   <= S_GAP;
                    end else begin
                        J     <= 1'b0;
                        K     <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                S_GAP: begin
                    J <= 1'b0;
                    K <= 1'b0;
                    if (gap_cnt <= 4'd1) begin
                        gap_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end

                default: begin
                    J     <= 1'b0;
                    K     <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef JK_SEQ_SHADOW_Q_EN
    // Mirrors the downstream flip-flop, which samples J/K on this clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_model <= 1'b0;
        end else begin
            unique case ({J, K})
                2'b01:   q_model <= 1'b0;
                2'b10:   q_model <= 1'b1;
                2'b11:   q_model <= ~q_model;
                default: q_model <= q_model;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: vector tables, directed corner sequences and random
// traffic against a token-queue reference model of the sequencer.

module tb_jk_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;

    logic       v;
    logic [1:0] op;
    logic [3:0] rep;
    logic       rdy0, j0, k0, busy0, done0;
    logic [2:0] cnt0;

    logic       v2;
    logic [1:0] op2;
    logic [3:0] rep2;
    logic       rdy2, j2, k2, busy2, done2;
    logic [2:0] cnt2;

`ifdef JK_SEQ_SHADOW_Q_EN
    logic q0, q2;
`endif

    jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .GAP_CYC(0)) dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid(v), .cmd_ready(rdy0),
        .cmd_op(op), .cmd_rep(rep),
        .J(j0), .K(k0), .busy(busy0), .done(done0),
        .fifo_cnt(cnt0)
`ifdef JK_SEQ_SHADOW_Q_EN
        , .q_model(q0)
`endif
    );

    jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .GAP_CYC(2)) dut2 (
        .clk(clk), .rst(rst),
        .cmd_valid(v2), .cmd_ready(rdy2),
        .cmd_op(op2), .cmd_rep(rep2),
        .J(j2), .K(k2), .busy(busy2), .done(done2),
        .fifo_cnt(cnt2)
`ifdef JK_SEQ_SHADOW_Q_EN
        , .q_model(q2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model for dut0: a command queue plus a queue of per-cycle
    // output tokens. A command expands into rep+1 tokens when the token
    // queue runs dry; J/K show one token per clock.
    typedef struct packed {
        logic [1:0] op;
        logic [3:0] rep;
    } cmd_t;

    typedef struct packed {
        logic j;
        logic k;
        logic d;
    } tok_t;

    cmd_t mq[$];
    tok_t sq[$];
    logic mj, mk, md, mcur, mq_q;

    task automatic model_reset();
        mq.delete();
        sq.delete();
        mj   = 1'b0;
        mk   = 1'b0;
        md   = 1'b0;
        mcur = 1'b0;
        mq_q = 1'b0;
    endtask

    task automatic model_edge();
        cmd_t c;
        tok_t t;
        int   pre;
        pre = mq.size();
        if (mj && mk)       mq_q = ~mq_q;
        else if (mj)        mq_q = 1'b1;
        else if (mk)        mq_q = 1'b0;
        if (sq.size() == 0 && mq.size() > 0) begin
            c = mq.pop_front();
            for (int i = 0; i <= int'(c.rep); i++) begin
                t.j = c.op[1];
                t.k = c.op[0];
                t.d = (i == int'(c.rep));
                sq.push_back(t);
            end
        end
        if (v && pre < DEPTH) begin
            c.op  = op;
            c.rep = rep;
            mq.push_back(c);
        end
        if (sq.size() > 0) begin
            t    = sq.pop_front();
            mj   = t.j;
            mk   = t.k;
            md   = t.d;
            mcur = 1'b1;
        end else begin
            mj   = 1'b0;
            mk   = 1'b0;
            md   = 1'b0;
            mcur = 1'b0;
        end
    endtask

    task automatic model_check();
        chk("m_j", int'(j0), int'(mj));
        chk("m_k", int'(k0), int'(mk));
        chk("m_done", int'(done0), int'(md));
        chk("m_cnt", int'(cnt0), mq.size());
        chk("m_ready", int'(rdy0), int'(mq.size() < DEPTH));
        chk("m_busy", int'(busy0),
            int'(sq.size() > 0 || mcur || mq.size() > 0));
`ifdef JK_SEQ_SHADOW_Q_EN
        chk("m_q", int'(q0), int'(mq_q));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [3:0] rep;
        logic       j;
        logic       k;
        logic       d;
        logic       busy;
        int         cnt;
    } vec_t;

    vec_t tv[6];
    vec_t gv[8];

    logic [5:0] pat;
    int         n;
    int         act;

    initial begin
        // single set command, rep=2, on dut0
        tv[0] = '{1'b1, 2'b10, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tv[1] = '{1'b0, 2'b00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        tv[2] = '{1'b0, 2'b00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        tv[3] = '{1'b0, 2'b00, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        tv[4] = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tv[5] = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        // two reset commands, rep=0, through dut2 (GAP_CYC=2)
        gv[0] = '{1'b1, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        gv[1] = '{1'b1, 2'b01, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1};
        gv[2] = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        gv[3] = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        gv[4] = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0};
        gv[5] = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        gv[6] = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        gv[7] = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        rst = 1'b0;
        v   = 1'b0; op  = 2'b00; rep  = 4'd0;
        v2  = 1'b0; op2 = 2'b00; rep2 = 4'd0;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_j", int'(j0), 0);
        chk("rst_k", int'(k0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_ready", int'(rdy0), 1);
        chk("rst_cnt", int'(cnt0), 0);
        chk("rst_busy2", int'(busy2), 0);
        chk("rst_ready2", int'(rdy2), 1);
        rst = 1'b1;

        // single command vectors
        for (int i = 0; i < 6; i++) begin
            v = tv[i].v; op = tv[i].op; rep = tv[i].rep;
            step();
            chk($sformatf("single_j[%0d]", i), int'(j0), int'(tv[i].j));
            chk($sformatf("single_k[%0d]", i), int'(k0), int'(tv[i].k));
            chk($sformatf("single_d[%0d]", i), int'(done0), int'(tv[i].d));
            chk($sformatf("single_b[%0d]", i), int'(busy0), int'(tv[i].busy));
            chk($sformatf("single_c[%0d]", i), int'(cnt0), tv[i].cnt);
        end

        // back-to-back toggles
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            v = (i < 3); op = 2'b11; rep = 4'd0;
            step();
            pat = {pat[4:0], j0 & k0 & done0};
        end
        chk("b2b_pattern", int'(pat), int'(6'b011100));
`ifdef JK_SEQ_SHADOW_Q_EN
        chk("b2b_q_end", int'(q0), 1);
`endif

        // fill the FIFO behind a long command
        v = 1'b1; op = 2'b10; rep = 4'd15;
        step();
        for (int i = 0; i < 5; i++) begin
            op = 2'(i); rep = 4'd0;
            step();
        end
        chk("fill_cnt", int'(cnt0), 4);
        chk("fill_ready", int'(rdy0), 0);
        v = 1'b0;
        n = 0;
        while (!rdy0 && n < 30) begin
            step();
            n++;
        end
        chk("fill_ready_back", int'(rdy0), 1);
        chk("fill_cnt_after_pop", int'(cnt0), 3);
        n = 0;
        while (busy0 && n < 60) begin
            step();
            n++;
        end
        chk("fill_drained", int'(busy0), 0);

        // gap sequence on dut2
        for (int i = 0; i < 8; i++) begin
            v2 = gv[i].v; op2 = gv[i].op; rep2 = gv[i].rep;
            step();
            chk($sformatf("gap_j[%0d]", i), int'(j2), int'(gv[i].j));
            chk($sformatf("gap_k[%0d]", i), int'(k2), int'(gv[i].k));
            chk($sformatf("gap_d[%0d]", i), int'(done2), int'(gv[i].d));
            chk($sformatf("gap_b[%0d]", i), int'(busy2), int'(gv[i].busy));
            chk($sformatf("gap_c[%0d]", i), int'(cnt2), gv[i].cnt);
        end

        // reset in the middle of a long command with two queued
        v = 1'b1; op = 2'b10; rep = 4'd7;
        step();
        op = 2'b01; rep = 4'd1;
        step();
        step();
        v = 1'b0;
        step();
        chk("mid_pre_j", int'(j0), 1);
        chk("mid_pre_cnt", int'(cnt0), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_j", int'(j0), 0);
        chk("mid_rst_k", int'(k0), 0);
        chk("mid_rst_cnt", int'(cnt0), 0);
        chk("mid_rst_busy", int'(busy0), 0);
        model_reset();
        #3;
        rst = 1'b1;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (j0 || k0 || busy0) act++;
        end
        chk("mid_quiet", act, 0);

        // random traffic, exercising pointer wrap and full/empty edges
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 99) < 55);
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0)
                rep = 4'($urandom_range(0, 15));
            else
                rep = 4'($urandom_range(0, 2));
            step();
        end
        v = 1'b0;
        n = 0;
        while (busy0 && n < 200) begin
            step();
            n++;
        end
        chk("rand_drained", int'(busy0), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
Upstream command stage for the JK flip-flop. It buffers hold/reset/set/toggle commands in a small FIFO and replays each one as a registered J/K pair for a programmable number of cycles. An optional inter-command gap can be inserted. Its J and K outputs connect directly to the flip-flop's J and K inputs on the same clk.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 4, width of the repeat field; a command drives for cmd_rep+1 cycles
GAP_CYC, 0, idle (J=K=0) cycles inserted after each command; 0..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (low = reset asserted)
cmd_valid  input  1  command present on cmd_op/cmd_rep
cmd_ready  output  1  FIFO can accept; equals !full
cmd_op  input  2  {J,K} encoding: 00 hold, 01 reset, 10 set, 11 toggle
cmd_rep  input  CNT_W  repeat count minus one
J  output  1  registered J drive
K  output  1  registered K drive
busy  output  1  high when FSM not IDLE or FIFO non-empty
done  output  1  high in the cycle J/K carry the last repetition of a command
fifo_cnt  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst low, asynchronous): FIFO pointers and count = 0, state = IDLE, J = K = 0, done = 0, repeat/gap counters = 0. busy = 0, cmd_ready = 1.
- Enqueue: occurs on a clk edge with cmd_valid && cmd_ready.
  - cmd_ready depends only on occupancy. When full, a same-cycle pop does not raise ready (no bypass).
  - cmd_valid while full is ignored and produces no error.
- FIFO: circular, read/write pointers wrap modulo DEPTH. Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
- FSM states:
  - IDLE: J=K=0. If FIFO non-empty, pop head, load op and rep_cnt=cmd_rep, go to ISSUE.
  - ISSUE: J/K = op. Each cycle rep_cnt decrements.
    - At rep_cnt==0: done=1 in that cycle.
    - If GAP_CYC>0, load gap_cnt=GAP_CYC-1 and go to GAP.
    - Else if FIFO non-empty, pop the next command and stay in ISSUE (seamless back-to-back).
    - Else go to IDLE.
  - GAP: J=K=0, gap_cnt decrements. At 0, go to IDLE (pop happens there).
- Latency: a command accepted at edge t into an empty, idle block drives J/K from edge t+1 for cmd_rep+1 cycles.
- J, K and done are registered outputs with no combinational path from inputs.
- Hold (00) commands still consume their full repeat time.
- Mid-operation reset: J/K drop to 0 immediately (asynchronously). All queued commands are discarded.
- rep_cnt is CNT_W bits. cmd_rep = all-ones gives 2^CNT_W cycles with no overflow.

Optional Feature:
Macro: JK_SEQ_SHADOW_Q_EN
- Defined:
  - Adds output q_model (1 bit), a registered model of the downstream flip-flop.
  - q_model updates each edge from the current J/K per the JK truth table.
  - Reset value is 0 on rst low.
  - Used as a bench reference.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then single command (op=10, rep=2) into an idle block: J=1, K=0 for exactly 3 cycles starting 1 edge after acceptance; done high on the 3rd; busy falls the cycle after.
- Back-to-back with GAP_CYC=0: enqueue op=11 rep=0 ×3 → J=K=1 for 3 contiguous cycles; done high each cycle; q_model (if enabled) goes 0→1→0→1.
- Fill with DEPTH=4 while FSM is stalled on a rep=15 command: cmd_ready low after 4 accepts; a 5th valid is dropped; fifo_cnt=4; ready returns only after a pop.
- GAP_CYC=2, two commands op=01 rep=0: J/K = 01, 00, 00, then 01; fifo_cnt sequence matches.
- Reset asserted mid-ISSUE (rep=7, 3 cycles in) with 2 queued: J=K=0 immediately and fifo_cnt=0; after release there is no further J/K activity without new commands.
- Pointer wrap: push/pop 10 mixed commands through a DEPTH=4 FIFO → issue order exactly matches push order.
